// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID reader and anything else that needs to
// agree with it: the FSM state encoding, the two word addresses of the
// system-ID slave, the default build timestamp, and the timeout counter width.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Build timestamp that the slave generator also uses, so both sides of
    // the check come from one source.
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1536784816;

    localparam int CTR_W = 16;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-transfer watchdog counter for the system-ID reader.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   clear       restart the count at zero (takes priority over enable)
//   enable      count this cycle
//   last_cycle  high while the current cycle is the TIMEOUT_CYCLES-th cycle
//               since the last clear, i.e. the last cycle a transfer may use
module sysid_timeout_ctr
    import sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic last_cycle
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT_CYCLES - 1);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of cycles already spent, so the terminal cycle
    // is the one where it equals TIMEOUT_CYCLES-1.
    assign last_cycle = (count == LAST);

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system ID (word 0) and build
// timestamp (word 1) from the system-ID slave, latches both, and compares
// them with the values this image was built against.
//
// Ports:
//   clock, reset_n       clock and synchronous active-low reset
//   start                one-cycle launch pulse, ignored while busy
//   avm_address/avm_read registered read request (address 0 = ID, 1 = TS)
//   avm_waitrequest      slave stall, request held while high
//   avm_readdatavalid    read data strobe
//   avm_readdata         read data
//   busy                 a check is in progress
//   done                 one-cycle pulse when a check ends
//   id_ok/ts_ok          latched compare results of the last check
//   timeout              latched: a transfer ran out of cycles
//   id_value/ts_value    last values read
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t state;
    logic   auto_pend;
    logic   launch;
    logic   data_in;
    logic   ctr_clear;
    logic   ctr_enable;
    logic   last_cycle;

    always_comb begin
        launch     = start || auto_pend;
        // Data counts in RD_* only when the request is accepted in the same
        // cycle (zero-latency slave); in WT_* any strobe is our data.
        data_in    = avm_readdatavalid &&
                     (((state == RD_ID || state == RD_TS) && !avm_waitrequest) ||
                      state == WT_ID || state == WT_TS);
        // The counter restarts on every entry to RD_*.
        ctr_clear  = (state == IDLE && launch) ||
                     (data_in && (state == RD_ID || state == WT_ID));
        ctr_enable = state inside {RD_ID, WT_ID, RD_TS, WT_TS};
    end

    sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (ctr_clear),
        .enable    (ctr_enable),
        .last_cycle(last_cycle)
    );

    always_ff @(posedge clock) begin
        done <= 1'b0;
        if (!reset_n) begin
            state       <= IDLE;
            auto_pend   <= AUTO_START;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        auto_pend   <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                        state       <= RD_ID;
                    end
                end
                RD_ID, WT_ID: begin
                    // Arriving data wins over a coincident terminal count.
                    if (data_in) begin
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_TS;
                        state       <= RD_TS;
                    end else if (last_cycle) begin
                        timeout  <= 1'b1;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (state == RD_ID && !avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= WT_ID;
                    end
                end
                RD_TS, WT_TS: begin
                    if (data_in) begin
                        ts_value <= avm_readdata;
                        ts_ok    <= (avm_readdata == EXPECTED_TS);
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (last_cycle) begin
                        timeout  <= 1'b1;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (state == RD_TS && !avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= WT_TS;
                    end
                end
                // A start seen here is not acted on; IDLE samples it next cycle.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: two instances (auto-start with an 8-cycle timeout,
// and manual start with the default timeout) each driven by a configurable
// Avalon slave model with stall count, read latency and an ID-mute option.
module tb_sysid_reader;
    import sysid_pkg::*;

    typedef struct {
        logic [31:0] id_value;
        logic [31:0] ts_value;
        logic        id_ok;
        logic        ts_ok;
        logic        timeout;
        int          cycles;
        int          accepts;
        int          ts_reqs;
    } exp_t;

    typedef struct {
        int          stall;
        int          lat;
        logic        mute_id;
        logic [31:0] id_data;
        logic [31:0] ts_data;
        exp_t        exp;
    } vec_t;

    localparam logic [31:0] GOOD_TS = DEFAULT_EXPECTED_TS;
    localparam logic [31:0] BAD_TS  = 32'h12345678;
    localparam logic [31:0] BAD_ID  = 32'hDEADBEEF;
    localparam logic [31:0] ODD_ID  = 32'hA5A5A5A5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  rst_n, start, avm_read, avm_address, wreq, rdv;
    logic [1:0]  busy, done, id_ok, ts_ok, timeout;
    logic [31:0] rdata [2];
    logic [31:0] id_value [2];
    logic [31:0] ts_value [2];

    // slave model configuration
    int          cfg_stall, cfg_lat;
    logic        cfg_mute_id;
    logic [31:0] cfg_id, cfg_ts;
    logic [1:0]  force_rdv;

    // slave model state
    int          stall_cnt [2];
    int          lat_cnt [2];
    logic [1:0]  pend, pend_addr;

    // bus monitor totals
    int          acc_cnt [2];
    int          ts_req_cnt [2];
    int          done_cnt [2];
    int          stab_err [2];
    int          ovl_err [2];
    logic [1:0]  stall_prev, stall_addr, outst;

    int          n_vec = 0;
    int          n_miss = 0;
    exp_t        sb_q [$];
    vec_t        vecs [6];

    sysid_reader #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b1)) dut_a (
        .clock(clock), .reset_n(rst_n[0]), .start(start[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(wreq[0]), .avm_readdatavalid(rdv[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
        .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0]));

    sysid_reader #(.AUTO_START(1'b0)) dut_b (
        .clock(clock), .reset_n(rst_n[1]), .start(start[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(wreq[1]), .avm_readdatavalid(rdv[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
        .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1]));

    // Slave: stall cfg_stall cycles per request, then return data cfg_lat
    // cycles after acceptance (0 = same cycle). Muted ID reads never return.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wreq[i]  = avm_read[i] && (stall_cnt[i] < cfg_stall);
            rdv[i]   = 1'b0;
            rdata[i] = 32'h0;
            if (avm_read[i] && !(stall_cnt[i] < cfg_stall) && cfg_lat == 0 &&
                !(cfg_mute_id && avm_address[i] == ADDR_ID)) begin
                rdv[i]   = 1'b1;
                rdata[i] = avm_address[i] ? cfg_ts : cfg_id;
            end
            if (pend[i] && lat_cnt[i] == 1) begin
                rdv[i]   = 1'b1;
                rdata[i] = pend_addr[i] ? cfg_ts : cfg_id;
            end
            if (force_rdv[i]) begin
                rdv[i]   = 1'b1;
                rdata[i] = cfg_ts;
            end
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                stall_cnt[i] <= 0;
                lat_cnt[i]   <= 0;
                pend[i]      <= 1'b0;
                pend_addr[i] <= 1'b0;
            end else begin
                if (wreq[i]) stall_cnt[i] <= stall_cnt[i] + 1;
                else         stall_cnt[i] <= 0;
                if (avm_read[i] && !wreq[i] && cfg_lat > 0 &&
                    !(cfg_mute_id && avm_address[i] == ADDR_ID)) begin
                    pend[i]      <= 1'b1;
                    lat_cnt[i]   <= cfg_lat;
                    pend_addr[i] <= avm_address[i];
                end else if (pend[i]) begin
                    if (lat_cnt[i] <= 1) pend[i] <= 1'b0;
                    else                 lat_cnt[i] <= lat_cnt[i] - 1;
                end
            end
        end
    end

    // Monitor: request stability under stall, single outstanding read,
    // accepted requests and done pulses.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                stall_prev[i] <= 1'b0;
                outst[i]      <= 1'b0;
            end else begin
                if (stall_prev[i] && busy[i] &&
                    (!avm_read[i] || avm_address[i] != stall_addr[i]))
                    stab_err[i] <= stab_err[i] + 1;
                stall_prev[i] <= wreq[i];
                stall_addr[i] <= avm_address[i];
                if (avm_read[i] && outst[i]) ovl_err[i] <= ovl_err[i] + 1;
                if (avm_read[i] && !wreq[i]) begin
                    acc_cnt[i] <= acc_cnt[i] + 1;
                    if (avm_address[i] == ADDR_TS) ts_req_cnt[i] <= ts_req_cnt[i] + 1;
                    outst[i] <= !rdv[i];
                end else if (rdv[i] || !busy[i]) begin
                    outst[i] <= 1'b0;
                end
                if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int stall, input int lat, input logic mute,
                                input logic [31:0] idd, input logic [31:0] tsd,
                                input logic eid_ok, input logic ets_ok, input logic eto,
                                input logic [31:0] eid, input logic [31:0] ets,
                                input int cyc, input int acc, input int tsr);
        vec_t v;
        v.stall = stall; v.lat = lat; v.mute_id = mute; v.id_data = idd; v.ts_data = tsd;
        v.exp.id_ok = eid_ok; v.exp.ts_ok = ets_ok; v.exp.timeout = eto;
        v.exp.id_value = eid; v.exp.ts_value = ets;
        v.exp.cycles = cyc; v.exp.accepts = acc; v.exp.ts_reqs = tsr;
        return v;
    endfunction

    task automatic set_slave(input int stall, input int lat, input logic mute,
                             input logic [31:0] idd, input logic [31:0] tsd);
        cfg_stall = stall; cfg_lat = lat; cfg_mute_id = mute; cfg_id = idd; cfg_ts = tsd;
    endtask

    // Vector 0 launches by releasing reset (auto-start); the rest by start.
    task automatic run_vec(input int k);
        vec_t v;
        exp_t e;
        int   n, acc0, tsr0, dn0;
        v = vecs[k];
        set_slave(v.stall, v.lat, v.mute_id, v.id_data, v.ts_data);
        acc0 = acc_cnt[0]; tsr0 = ts_req_cnt[0]; dn0 = done_cnt[0];
        sb_q.push_back(v.exp);
        if (k == 0) rst_n[0] = 1'b1;
        else        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        check($sformatf("v%0d_busy_launch", k), 32'(busy[0]), 32'd1);
        n = 0;
        while (!done[0] && n < 40) begin
            @(negedge clock);
            n++;
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d_done_seen", k), 32'(done[0]), 32'd1);
        check($sformatf("v%0d_cycles", k), 32'(n), 32'(e.cycles));
        check($sformatf("v%0d_busy_done", k), 32'(busy[0]), 32'd0);
        check($sformatf("v%0d_id_ok", k), 32'(id_ok[0]), 32'(e.id_ok));
        check($sformatf("v%0d_ts_ok", k), 32'(ts_ok[0]), 32'(e.ts_ok));
        check($sformatf("v%0d_timeout", k), 32'(timeout[0]), 32'(e.timeout));
        check($sformatf("v%0d_id_value", k), id_value[0], e.id_value);
        check($sformatf("v%0d_ts_value", k), ts_value[0], e.ts_value);
        @(negedge clock);
        check($sformatf("v%0d_done_width", k), 32'(done[0]), 32'd0);
        check($sformatf("v%0d_done_count", k), 32'(done_cnt[0] - dn0), 32'd1);
        check($sformatf("v%0d_accepts", k), 32'(acc_cnt[0] - acc0), 32'(e.accepts));
        check($sformatf("v%0d_ts_reqs", k), 32'(ts_req_cnt[0] - tsr0), 32'(e.ts_reqs));
        repeat (2) @(negedge clock);
    endtask

    task automatic check_zero_b(input string tag);
        check({tag, "_ctl"}, 32'({avm_read[1], avm_address[1], busy[1], done[1],
                                  id_ok[1], ts_ok[1], timeout[1]}), 32'd0);
        check({tag, "_id_value"}, id_value[1], 32'd0);
        check({tag, "_ts_value"}, ts_value[1], 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0, tsr0, dn0, n;
        rst_n = 2'b00; start = 2'b00; force_rdv = 2'b00;
        set_slave(0, 0, 1'b0, 32'd0, GOOD_TS);

        vecs[0] = mk(0,  0, 1'b0, 32'd0,  GOOD_TS, 1'b1, 1'b1, 1'b0, 32'd0,  GOOD_TS, 2,  2, 1);
        vecs[1] = mk(4,  2, 1'b0, 32'd0,  GOOD_TS, 1'b1, 1'b1, 1'b0, 32'd0,  GOOD_TS, 14, 2, 1);
        vecs[2] = mk(0,  0, 1'b0, 32'd0,  BAD_TS,  1'b1, 1'b0, 1'b0, 32'd0,  BAD_TS,  2,  2, 1);
        vecs[3] = mk(0,  0, 1'b1, 32'd0,  GOOD_TS, 1'b0, 1'b0, 1'b1, 32'd0,  BAD_TS,  8,  1, 0);
        vecs[4] = mk(1,  1, 1'b0, BAD_ID, GOOD_TS, 1'b0, 1'b1, 1'b0, BAD_ID, GOOD_TS, 6,  2, 1);
        vecs[5] = mk(20, 0, 1'b0, 32'd0,  GOOD_TS, 1'b0, 1'b0, 1'b1, BAD_ID, GOOD_TS, 8,  0, 0);

        repeat (3) @(negedge clock);
        check("reset_ctl", 32'({avm_read[0], avm_address[0], busy[0], done[0],
                                id_ok[0], ts_ok[0], timeout[0]}), 32'd0);
        check("reset_id_value", id_value[0], 32'd0);
        check("reset_ts_value", ts_value[0], 32'd0);

        for (int k = 0; k < 6; k++) run_vec(k);
        check("a_stall_stability", 32'(stab_err[0]), 32'd0);
        check("a_single_outstanding", 32'(ovl_err[0]), 32'd0);

        // Manual-start instance: no auto launch, one check despite a busy start.
        set_slave(4, 2, 1'b0, 32'd0, GOOD_TS);
        rst_n[1] = 1'b1;
        repeat (4) @(negedge clock);
        check("b_no_autostart_read", 32'(avm_read[1]), 32'd0);
        check("b_no_autostart_busy", 32'(busy[1]), 32'd0);
        acc0 = acc_cnt[1]; tsr0 = ts_req_cnt[1]; dn0 = done_cnt[1];
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        repeat (2) @(negedge clock);
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        repeat (30) @(negedge clock);
        check("b_done_count", 32'(done_cnt[1] - dn0), 32'd1);
        check("b_accepts", 32'(acc_cnt[1] - acc0), 32'd2);
        check("b_ts_reqs", 32'(ts_req_cnt[1] - tsr0), 32'd1);
        check("b_oks", 32'({id_ok[1], ts_ok[1], timeout[1]}), 32'b110);
        check("b_busy_idle", 32'(busy[1]), 32'd0);

        // Reset while waiting for the timestamp, with a late strobe during
        // reset and in the first IDLE cycle after it.
        set_slave(0, 2, 1'b0, ODD_ID, GOOD_TS);
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        repeat (4) @(negedge clock);
        check("b_pre_reset_id", id_value[1], ODD_ID);
        check("b_pre_reset_wait", 32'({busy[1], avm_read[1]}), 32'b10);
        rst_n[1] = 1'b0;
        force_rdv[1] = 1'b1;
        @(negedge clock);
        check_zero_b("b_in_reset");
        rst_n[1] = 1'b1;
        @(negedge clock);
        force_rdv[1] = 1'b0;
        check_zero_b("b_late_rdv");
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            check_zero_b($sformatf("b_idle_%0d", j));
        end
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        check("b_relaunch_read", 32'({avm_read[1], avm_address[1], busy[1]}), 32'b101);
        n = 0;
        while (!done[1] && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b_relaunch_done", 32'(done[1]), 32'd1);
        check("b_stall_stability", 32'(stab_err[1]), 32'd0);
        check("b_single_outstanding", 32'(ovl_err[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
